nfc_command_dispatcher: RTL and testbench
=========================================

Name: nfc_command_dispatcher

Overview:
Sits between the host command channel and the NFC_Command_* modules (EraseBlock, ProgramPage, ReadPage, Reset, ...), all of which share one atomic command generator (ACG) port. It broadcasts host CMDValid, latches which command module claimed the command from its Start pulse, and gives that module sole ownership of the ACG interface until its LastStep. A watchdog counter force-releases ownership if a command hangs.

Parameters:
NumberOfWays, 4, way-select width on the ACG TargetWay field
NumberOfCmds, 4, number of attached command modules (index 0..N-1)
TimeoutWidth, 24, watchdog counter width; timeout fires at all-ones count

Ports:
iSystemClock  in  1  system clock
iReset  in  1  reset
iCMDValid  in  1  host command valid (opcode/target/address are wired straight to the command modules, not through this block)
oCMDReady  out  1  host may issue a command
oCmd_CMDValid  out  1  broadcast valid to all command modules
iCmd_CMDReady  in  N  per-module CMDReady
iCmd_Start  in  N  per-module oStart (combinational opcode decode & valid)
iCmd_LastStep  in  N  per-module oLastStep
iCmd_ACG_Command  in  8*N  per-module ACG command, slice i = [8i+7:8i]; same slicing for all packed buses below
iCmd_ACG_CommandOption  in  3*N
iCmd_ACG_TargetWay  in  NumberOfWays*N
iCmd_ACG_NumOfData  in  16*N
iCmd_ACG_CASelect  in  N
iCmd_ACG_CAData  in  40*N
oCmd_ACG_Ready  out  8*N  ACG Ready routed to owner only
oCmd_ACG_LastStep  out  8*N  ACG LastStep routed to owner only
oACG_Command  out  8
oACG_CommandOption  out  3
oACG_TargetWay  out  NumberOfWays
oACG_NumOfData  out  16
oACG_CASelect  out  1
oACG_CAData  out  40
iACG_Ready  in  8
iACG_LastStep  in  8
oOwner  out  N  one-hot current owner, 0 when idle
oDecodeError  out  1  sticky: no Start or multiple Starts on an accepted valid
oTimeout  out  1  sticky: watchdog fired

Behaviour:
- Reset is synchronous, active-high. On reset: state IDLE, oOwner=0, oDecodeError=0, oTimeout=0, watchdog=0, oACG_* at idle values (Command 0, Option 0, TargetWay 0, NumOfData 0, CASelect 1, CAData 0). Reset mid-ownership drops ownership immediately.
- oCMDReady = (state==IDLE) & (&iCmd_CMDReady). oCmd_CMDValid = iCMDValid & oCMDReady.
- States: IDLE, OWN.
- IDLE, accept cycle T (oCmd_CMDValid=1):
  - exactly one Start bit: owner<=that one-hot; OWN at T+1; watchdog cleared.
  - several Start bits: lowest index owns; oDecodeError<=1.
  - no Start bit: stay IDLE; oDecodeError<=1.
- OWN: oACG_* = owner's slice, combinational mux on registered owner (no added latency). Owner's oCmd_ACG_Ready/LastStep = iACG_Ready/iACG_LastStep; all other slices 0.
- OWN->IDLE when the owner's iCmd_LastStep=1 at cycle L; IDLE (oCMDReady may be 1) at L+1. LastStep from a non-owner is ignored.
- Watchdog increments by 1 each OWN cycle. At all-ones: oTimeout<=1, owner<=0, IDLE next cycle. LastStep in the same cycle takes priority; no timeout flagged.
- IDLE: oACG_* at idle values; all oCmd_ACG_Ready/LastStep slices 0.
- Sticky flags clear only on reset.

Decomposition:
- Shared package nfc_dispatch_pkg: state encodings (IDLE, OWN); ACG idle constants (command 8'h00, CASelect 1'b1, CAData 40'h0); field widths 8/3/16/40.
- One sub-module, nfc_acg_owner_mux: one-hot-select mux of all ACG fields plus the return-path demux. Parameterised on NumberOfCmds and NumberOfWays. Purely combinational; the FSM and watchdog stay in the top.

Test Plan:
- Reset, then idle: oCMDReady=1, oACG_CASelect=1, oACG_CAData=0, oOwner=0.
- iCMDValid with iCmd_Start=4'b0010; module 1 drives Command 8'h08, CAData 40'h60_00_00_00_00 -> oOwner=4'b0010 next cycle, oACG_CAData=40'h60_00_00_00_00, only slice 1 sees iACG_Ready=8'hFF; oCMDReady=0 until the cycle after iCmd_LastStep[1].
- iCMDValid with iCmd_Start=4'b0000 -> stays IDLE, oDecodeError=1 next cycle; iCmd_Start=4'b0110 -> owner 4'b0010, oDecodeError=1.
- During ownership by module 1, pulse iCmd_LastStep[2] -> ignored, still OWN; module 2 ACG slices stay 0.
- TimeoutWidth=4: hold ownership 15 cycles with no LastStep -> oTimeout=1, oOwner=0, IDLE; with LastStep in the firing cycle -> oTimeout stays 0.
- Assert iReset during OWN -> next cycle oOwner=0, oACG_Command=0, oCMDReady=1 once all iCmd_CMDReady=1.

Source files
------------

// File: rtl/nfc_dispatch_pkg.sv
// Shared types and constants for the NFC command dispatcher: FSM state encoding,
// ACG field widths and the values the ACG port holds while no command owns it.
package nfc_dispatch_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_e;

  localparam int ACG_CMD_W  = 8;
  localparam int ACG_OPT_W  = 3;
  localparam int ACG_NOD_W  = 16;
  localparam int ACG_CAD_W  = 40;
  localparam int ACG_RET_W  = 8;

  localparam logic [ACG_CMD_W-1:0] ACG_IDLE_COMMAND  = 8'h00;
  localparam logic [ACG_OPT_W-1:0] ACG_IDLE_OPTION   = 3'h0;
  localparam logic [ACG_NOD_W-1:0] ACG_IDLE_NUMDATA  = 16'h0000;
  localparam logic                 ACG_IDLE_CASELECT = 1'b1;
  localparam logic [ACG_CAD_W-1:0] ACG_IDLE_CADATA   = 40'h00_0000_0000;

endpackage

// File: rtl/nfc_acg_owner_mux.sv
// One-hot owner select of the command modules' ACG request fields onto the
// shared ACG port, and demux of the ACG Ready/LastStep return path to the owner.
module nfc_acg_owner_mux
  import nfc_dispatch_pkg::*;
#(
  parameter int NumberOfCmds = 4,
  parameter int NumberOfWays = 4
) (
  input  logic [NumberOfCmds-1:0]              iSel,
  input  logic [ACG_CMD_W*NumberOfCmds-1:0]    iCmd_ACG_Command,
  input  logic [ACG_OPT_W*NumberOfCmds-1:0]    iCmd_ACG_CommandOption,
  input  logic [NumberOfWays*NumberOfCmds-1:0] iCmd_ACG_TargetWay,
  input  logic [ACG_NOD_W*NumberOfCmds-1:0]    iCmd_ACG_NumOfData,
  input  logic [NumberOfCmds-1:0]              iCmd_ACG_CASelect,
  input  logic [ACG_CAD_W*NumberOfCmds-1:0]    iCmd_ACG_CAData,
  input  logic [ACG_RET_W-1:0]                 iACG_Ready,
  input  logic [ACG_RET_W-1:0]                 iACG_LastStep,
  output logic [ACG_CMD_W-1:0]                 oACG_Command,
  output logic [ACG_OPT_W-1:0]                 oACG_CommandOption,
  output logic [NumberOfWays-1:0]              oACG_TargetWay,
  output logic [ACG_NOD_W-1:0]                 oACG_NumOfData,
  output logic                                 oACG_CASelect,
  output logic [ACG_CAD_W-1:0]                 oACG_CAData,
  output logic [ACG_RET_W*NumberOfCmds-1:0]    oCmd_ACG_Ready,
  output logic [ACG_RET_W*NumberOfCmds-1:0]    oCmd_ACG_LastStep
);

  always_comb begin
    oCmd_ACG_Ready    = '0;
    oCmd_ACG_LastStep = '0;
    if (iSel == '0) begin
      oACG_Command       = ACG_IDLE_COMMAND;
      oACG_CommandOption = ACG_IDLE_OPTION;
      oACG_TargetWay     = '0;
      oACG_NumOfData     = ACG_IDLE_NUMDATA;
      oACG_CASelect      = ACG_IDLE_CASELECT;
      oACG_CAData        = ACG_IDLE_CADATA;
    end else begin
      // Select is one-hot, so OR-ing the selected slices onto a zero base is a plain mux.
      oACG_Command       = '0;
      oACG_CommandOption = '0;
      oACG_TargetWay     = '0;
      oACG_NumOfData     = '0;
      oACG_CASelect      = 1'b0;
      oACG_CAData        = '0;
      for (int i = 0; i < NumberOfCmds; i++) begin
        if (iSel[i]) begin
          oACG_Command       = oACG_Command       | iCmd_ACG_Command[ACG_CMD_W*i +: ACG_CMD_W];
          oACG_CommandOption = oACG_CommandOption | iCmd_ACG_CommandOption[ACG_OPT_W*i +: ACG_OPT_W];
          oACG_TargetWay     = oACG_TargetWay     | iCmd_ACG_TargetWay[NumberOfWays*i +: NumberOfWays];
          oACG_NumOfData     = oACG_NumOfData     | iCmd_ACG_NumOfData[ACG_NOD_W*i +: ACG_NOD_W];
          oACG_CASelect      = oACG_CASelect      | iCmd_ACG_CASelect[i];
          oACG_CAData        = oACG_CAData        | iCmd_ACG_CAData[ACG_CAD_W*i +: ACG_CAD_W];
          oCmd_ACG_Ready[ACG_RET_W*i +: ACG_RET_W]    = iACG_Ready;
          oCmd_ACG_LastStep[ACG_RET_W*i +: ACG_RET_W] = iACG_LastStep;
        end
      end
    end
  end

endmodule

// File: rtl/nfc_command_dispatcher.sv
// Arbitrates the shared ACG port between NFC command modules: the module whose
// Start fires on an accepted host valid owns the ACG until its LastStep or a watchdog timeout.
module nfc_command_dispatcher
  import nfc_dispatch_pkg::*;
#(
  parameter int NumberOfWays = 4,
  parameter int NumberOfCmds = 4,
  parameter int TimeoutWidth = 24
) (
  input  logic                                 iSystemClock,
  input  logic                                 iReset,
  input  logic                                 iCMDValid,
  output logic                                 oCMDReady,
  output logic                                 oCmd_CMDValid,
  input  logic [NumberOfCmds-1:0]              iCmd_CMDReady,
  input  logic [NumberOfCmds-1:0]              iCmd_Start,
  input  logic [NumberOfCmds-1:0]              iCmd_LastStep,
  input  logic [ACG_CMD_W*NumberOfCmds-1:0]    iCmd_ACG_Command,
  input  logic [ACG_OPT_W*NumberOfCmds-1:0]    iCmd_ACG_CommandOption,
  input  logic [NumberOfWays*NumberOfCmds-1:0] iCmd_ACG_TargetWay,
  input  logic [ACG_NOD_W*NumberOfCmds-1:0]    iCmd_ACG_NumOfData,
  input  logic [NumberOfCmds-1:0]              iCmd_ACG_CASelect,
  input  logic [ACG_CAD_W*NumberOfCmds-1:0]    iCmd_ACG_CAData,
  output logic [ACG_RET_W*NumberOfCmds-1:0]    oCmd_ACG_Ready,
  output logic [ACG_RET_W*NumberOfCmds-1:0]    oCmd_ACG_LastStep,
  output logic [ACG_CMD_W-1:0]                 oACG_Command,
  output logic [ACG_OPT_W-1:0]                 oACG_CommandOption,
  output logic [NumberOfWays-1:0]              oACG_TargetWay,
  output logic [ACG_NOD_W-1:0]                 oACG_NumOfData,
  output logic                                 oACG_CASelect,
  output logic [ACG_CAD_W-1:0]                 oACG_CAData,
  input  logic [ACG_RET_W-1:0]                 iACG_Ready,
  input  logic [ACG_RET_W-1:0]                 iACG_LastStep,
  output logic [NumberOfCmds-1:0]              oOwner,
  output logic                                 oDecodeError,
  output logic                                 oTimeout
);

  state_e                    state_q, state_d;
  logic [NumberOfCmds-1:0]   owner_q, owner_d;
  logic [TimeoutWidth-1:0]   watchdog_q, watchdog_d;
  logic                      decode_error_q, decode_error_d;
  logic                      timeout_q, timeout_d;

  logic                      cmd_ready;
  logic                      accept;
  logic [NumberOfCmds-1:0]   start_lowest;
  logic                      start_multi;
  logic                      owner_last;
  logic [TimeoutWidth-1:0]   watchdog_inc;

  assign cmd_ready    = (state_q == ST_IDLE) && (&iCmd_CMDReady);
  assign accept       = iCMDValid && cmd_ready;
  assign start_lowest = iCmd_Start & (~iCmd_Start + NumberOfCmds'(1));
  assign start_multi  = |(iCmd_Start & (iCmd_Start - NumberOfCmds'(1)));
  assign owner_last   = |(owner_q & iCmd_LastStep);
  assign watchdog_inc = watchdog_q + TimeoutWidth'(1);

  // NOTE: every always_comb output gets a default before any branch, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    watchdog_d     = watchdog_q;
    decode_error_d = decode_error_q;
    timeout_d      = timeout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if ((iCmd_Start == '0) || start_multi) decode_error_d = 1'b1;
          if (iCmd_Start != '0) begin
            owner_d    = start_lowest;
            state_d    = ST_OWN;
            watchdog_d = '0;
          end
        end
      end
      ST_OWN: begin
        // The watchdog counts OWN cycles; the cycle whose count reaches all-ones
        // is the last one. A LastStep in that same cycle wins over the timeout.
        if (owner_last) begin
          owner_d = '0;
          state_d = ST_IDLE;
        end else if (&watchdog_inc) begin
          timeout_d = 1'b1;
          owner_d   = '0;
          state_d   = ST_IDLE;
        end else begin
          watchdog_d = watchdog_inc;
        end
      end
      default: begin
        owner_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the clock edge, independent of statement order.
  always_ff @(posedge iSystemClock) begin
    if (iReset) begin
      state_q        <= ST_IDLE;
      owner_q        <= '0;
      watchdog_q     <= '0;
      decode_error_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      watchdog_q     <= watchdog_d;
      decode_error_q <= decode_error_d;
      timeout_q      <= timeout_d;
    end
  end

  assign oCMDReady     = cmd_ready;
  assign oCmd_CMDValid = accept;
  assign oOwner        = owner_q;
  assign oDecodeError  = decode_error_q;
  assign oTimeout      = timeout_q;

  nfc_acg_owner_mux #(
    .NumberOfCmds (NumberOfCmds),
    .NumberOfWays (NumberOfWays)
  ) u_owner_mux (
    .iSel                   (owner_q),
    .iCmd_ACG_Command       (iCmd_ACG_Command),
    .iCmd_ACG_CommandOption (iCmd_ACG_CommandOption),
    .iCmd_ACG_TargetWay     (iCmd_ACG_TargetWay),
    .iCmd_ACG_NumOfData     (iCmd_ACG_NumOfData),
    .iCmd_ACG_CASelect      (iCmd_ACG_CASelect),
    .iCmd_ACG_CAData        (iCmd_ACG_CAData),
    .iACG_Ready             (iACG_Ready),
    .iACG_LastStep          (iACG_LastStep),
    .oACG_Command           (oACG_Command),
    .oACG_CommandOption     (oACG_CommandOption),
    .oACG_TargetWay         (oACG_TargetWay),
    .oACG_NumOfData         (oACG_NumOfData),
    .oACG_CASelect          (oACG_CASelect),
    .oACG_CAData            (oACG_CAData),
    .oCmd_ACG_Ready         (oCmd_ACG_Ready),
    .oCmd_ACG_LastStep      (oCmd_ACG_LastStep)
  );

endmodule

// File: tb/tb_nfc_command_dispatcher.sv
// Self-checking bench for nfc_command_dispatcher: directed scenarios plus a random
// run compared cycle by cycle against an owner-index/cycle-count reference model.
module tb_nfc_command_dispatcher;

  localparam int N          = 4;
  localparam int W          = 4;
  localparam int TW         = 4;
  localparam int TO_CYCLES  = (1 << TW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         cmd_valid;
  logic [N-1:0] cmd_rdy, start, last;
  logic [7:0]   acg_rdy, acg_last;

  logic [7:0]   f_cmd [N];
  logic [2:0]   f_opt [N];
  logic [W-1:0] f_way [N];
  logic [15:0]  f_nod [N];
  logic         f_cas [N];
  logic [39:0]  f_cad [N];

  logic [8*N-1:0]  b_cmd;
  logic [3*N-1:0]  b_opt;
  logic [W*N-1:0]  b_way;
  logic [16*N-1:0] b_nod;
  logic [N-1:0]    b_cas;
  logic [40*N-1:0] b_cad;

  always_comb begin
    b_cmd = '0; b_opt = '0; b_way = '0; b_nod = '0; b_cas = '0; b_cad = '0;
    for (int i = 0; i < N; i++) begin
      b_cmd[8*i +: 8]   = f_cmd[i];
      b_opt[3*i +: 3]   = f_opt[i];
      b_way[W*i +: W]   = f_way[i];
      b_nod[16*i +: 16] = f_nod[i];
      b_cas[i]          = f_cas[i];
      b_cad[40*i +: 40] = f_cad[i];
    end
  end

  logic            o_ready, o_valid, o_cas, o_err, o_to;
  logic [8*N-1:0]  o_rret, o_lret;
  logic [7:0]      o_cmd;
  logic [2:0]      o_opt;
  logic [W-1:0]    o_way;
  logic [15:0]     o_nod;
  logic [39:0]     o_cad;
  logic [N-1:0]    o_owner;

  nfc_command_dispatcher #(
    .NumberOfWays (W),
    .NumberOfCmds (N),
    .TimeoutWidth (TW)
  ) dut (
    .iSystemClock           (clk),
    .iReset                 (rst),
    .iCMDValid              (cmd_valid),
    .oCMDReady              (o_ready),
    .oCmd_CMDValid          (o_valid),
    .iCmd_CMDReady          (cmd_rdy),
    .iCmd_Start             (start),
    .iCmd_LastStep          (last),
    .iCmd_ACG_Command       (b_cmd),
    .iCmd_ACG_CommandOption (b_opt),
    .iCmd_ACG_TargetWay     (b_way),
    .iCmd_ACG_NumOfData     (b_nod),
    .iCmd_ACG_CASelect      (b_cas),
    .iCmd_ACG_CAData        (b_cad),
    .oCmd_ACG_Ready         (o_rret),
    .oCmd_ACG_LastStep      (o_lret),
    .oACG_Command           (o_cmd),
    .oACG_CommandOption     (o_opt),
    .oACG_TargetWay         (o_way),
    .oACG_NumOfData         (o_nod),
    .oACG_CASelect          (o_cas),
    .oACG_CAData            (o_cad),
    .iACG_Ready             (acg_rdy),
    .iACG_LastStep          (acg_last),
    .oOwner                 (o_owner),
    .oDecodeError           (o_err),
    .oTimeout               (o_to)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: owner index (-1 when free), OWN cycles elapsed, sticky flags.
  int   m_owner;
  int   m_cycles;
  logic m_err, m_to;

  logic            e_ready, e_valid, e_cas;
  logic [N-1:0]    e_owner;
  logic [7:0]      e_cmd;
  logic [2:0]      e_opt;
  logic [W-1:0]    e_way;
  logic [15:0]     e_nod;
  logic [39:0]     e_cad;
  logic [8*N-1:0]  e_rret, e_lret;

  task automatic model_expect();
    e_ready = (m_owner < 0) && (&cmd_rdy);
    e_valid = cmd_valid && e_ready;
    e_owner = '0; e_cmd = '0; e_opt = '0; e_way = '0; e_nod = '0; e_cas = 1'b1; e_cad = '0;
    e_rret  = '0; e_lret = '0;
    if (m_owner >= 0) begin
      e_owner[m_owner] = 1'b1;
      e_cmd = f_cmd[m_owner]; e_opt = f_opt[m_owner]; e_way = f_way[m_owner];
      e_nod = f_nod[m_owner]; e_cas = f_cas[m_owner]; e_cad = f_cad[m_owner];
      e_rret[8*m_owner +: 8] = acg_rdy;
      e_lret[8*m_owner +: 8] = acg_last;
    end
  endtask

  task automatic model_clock();
    int n;
    int low;
    if (rst) begin
      m_owner = -1; m_cycles = 0; m_err = 1'b0; m_to = 1'b0;
    end else if (m_owner < 0) begin
      if (cmd_valid && (&cmd_rdy)) begin
        n = 0; low = -1;
        for (int i = 0; i < N; i++) begin
          if (start[i]) begin
            n++;
            if (low < 0) low = i;
          end
        end
        if (n != 1) m_err = 1'b1;
        if (low >= 0) begin
          m_owner  = low;
          m_cycles = 0;
        end
      end
    end else begin
      m_cycles++;
      if (last[m_owner]) m_owner = -1;
      else if (m_cycles == TO_CYCLES) begin
        m_to    = 1'b1;
        m_owner = -1;
      end
    end
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
    model_expect();
  endtask

  task automatic idle_inputs();
    cmd_valid = 1'b0; start = '0; last = '0; cmd_rdy = '1; acg_rdy = '0; acg_last = '0;
  endtask

  task automatic randomize_fields();
    for (int i = 0; i < N; i++) begin
      f_cmd[i] = 8'($urandom); f_opt[i] = 3'($urandom); f_way[i] = W'($urandom);
      f_nod[i] = 16'($urandom); f_cas[i] = 1'($urandom);
      f_cad[i] = {8'($urandom), 32'($urandom)};
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic claim(input logic [N-1:0] s);
    cmd_valid = 1'b1; start = s;
    tick();
    cmd_valid = 1'b0; start = '0;
  endtask

  task automatic test_reset();
    randomize_fields();
    do_reset();
    settle();
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    total++; if (o_cas !== 1'b1) begin bad++; $display("FAIL reset_caselect got=%b exp=1", o_cas); end
    total++; if (o_cad !== 40'h0) begin bad++; $display("FAIL reset_cadata got=%h exp=0", o_cad); end
    total++; if (o_owner !== 4'b0000) begin bad++; $display("FAIL reset_owner got=%b exp=0000", o_owner); end
    total++; if ({o_err, o_to} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {o_err, o_to}); end
  endtask

  task automatic test_claim_release();
    randomize_fields();
    f_cmd[1] = 8'h08; f_cad[1] = 40'h60_00_00_00_00;
    cmd_valid = 1'b1; start = 4'b0010;
    settle();
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL claim_bcast_valid got=%b exp=1", o_valid); end
    tick();
    cmd_valid = 1'b0; start = '0; acg_rdy = 8'hFF;
    settle();
    total++; if (o_owner !== 4'b0010) begin bad++; $display("FAIL claim_owner got=%b exp=0010", o_owner); end
    total++; if (o_cad !== 40'h60_00_00_00_00) begin bad++; $display("FAIL claim_cadata got=%h exp=6000000000", o_cad); end
    total++; if (o_cmd !== 8'h08) begin bad++; $display("FAIL claim_command got=%h exp=08", o_cmd); end
    total++; if (o_rret !== 32'h0000_FF00) begin bad++; $display("FAIL claim_ready_route got=%h exp=0000ff00", o_rret); end
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL claim_busy got=%b exp=0", o_ready); end
    tick(); tick();
    last = 4'b0010;
    settle();
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL claim_busy_at_last got=%b exp=0", o_ready); end
    total++; if (o_owner !== 4'b0010) begin bad++; $display("FAIL claim_owner_at_last got=%b exp=0010", o_owner); end
    tick();
    last = '0; acg_rdy = '0;
    settle();
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b exp=1", o_ready); end
    total++; if (o_owner !== 4'b0000) begin bad++; $display("FAIL release_owner got=%b exp=0000", o_owner); end
    // Back-to-back: a new command right in the first free cycle.
    claim(4'b1000);
    settle();
    total++; if (o_owner !== 4'b1000) begin bad++; $display("FAIL b2b_owner got=%b exp=1000", o_owner); end
    total++; if (o_cmd !== f_cmd[3]) begin bad++; $display("FAIL b2b_command got=%h exp=%h", o_cmd, f_cmd[3]); end
    last = 4'b1000;
    tick();
    last = '0;
  endtask

  task automatic test_decode_error();
    do_reset();
    cmd_valid = 1'b1; start = 4'b0000;
    tick();
    cmd_valid = 1'b0;
    settle();
    total++; if (o_err !== 1'b1) begin bad++; $display("FAIL decode_none_err got=%b exp=1", o_err); end
    total++; if (o_owner !== 4'b0000) begin bad++; $display("FAIL decode_none_owner got=%b exp=0000", o_owner); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL decode_none_ready got=%b exp=1", o_ready); end
    claim(4'b0110);
    settle();
    total++; if (o_owner !== 4'b0010) begin bad++; $display("FAIL decode_multi_owner got=%b exp=0010", o_owner); end
    total++; if (o_err !== 1'b1) begin bad++; $display("FAIL decode_multi_err got=%b exp=1", o_err); end
    last = 4'b0010;
    tick();
    last = '0;
  endtask

  task automatic test_foreign_laststep();
    do_reset();
    randomize_fields();
    claim(4'b0010);
    last = 4'b0100; acg_rdy = 8'hA5; acg_last = 8'hFF;
    settle();
    total++; if (o_rret[23:16] !== 8'h00) begin bad++; $display("FAIL foreign_ready_slice got=%h exp=00", o_rret[23:16]); end
    total++; if (o_lret[23:16] !== 8'h00) begin bad++; $display("FAIL foreign_last_slice got=%h exp=00", o_lret[23:16]); end
    total++; if (o_lret[15:8] !== 8'hFF) begin bad++; $display("FAIL owner_last_slice got=%h exp=ff", o_lret[15:8]); end
    tick();
    last = '0;
    settle();
    total++; if (o_owner !== 4'b0010) begin bad++; $display("FAIL foreign_still_own got=%b exp=0010", o_owner); end
    total++; if (o_err !== 1'b0) begin bad++; $display("FAIL foreign_no_err got=%b exp=0", o_err); end
    last = 4'b0010;
    tick();
    idle_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    claim(4'b0001);
    for (int c = 1; c <= TO_CYCLES; c++) begin
      settle();
      total++; if (o_owner !== 4'b0001 || o_to !== 1'b0) begin bad++; $display("FAIL timeout_hold c=%0d owner=%b to=%b exp=0001/0", c, o_owner, o_to); end
      tick();
    end
    settle();
    total++; if (o_to !== 1'b1) begin bad++; $display("FAIL timeout_flag got=%b exp=1", o_to); end
    total++; if (o_owner !== 4'b0000) begin bad++; $display("FAIL timeout_owner got=%b exp=0000", o_owner); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL timeout_ready got=%b exp=1", o_ready); end
    tick();
    settle();
    total++; if (o_to !== 1'b1) begin bad++; $display("FAIL timeout_sticky got=%b exp=1", o_to); end
  endtask

  task automatic test_timeout_laststep();
    do_reset();
    claim(4'b1000);
    for (int c = 1; c < TO_CYCLES; c++) tick();
    last = 4'b1000;
    tick();
    last = '0;
    settle();
    total++; if (o_to !== 1'b0) begin bad++; $display("FAIL last_beats_timeout_flag got=%b exp=0", o_to); end
    total++; if (o_owner !== 4'b0000) begin bad++; $display("FAIL last_beats_timeout_owner got=%b exp=0000", o_owner); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL last_beats_timeout_ready got=%b exp=1", o_ready); end
  endtask

  task automatic test_reset_mid_own();
    do_reset();
    randomize_fields();
    f_cmd[2] = 8'hA5;
    claim(4'b0100);
    tick();
    settle();
    total++; if (o_cmd !== 8'hA5) begin bad++; $display("FAIL midrst_pre_command got=%h exp=a5", o_cmd); end
    rst = 1'b1; cmd_rdy = 4'b0111;
    tick();
    rst = 1'b0;
    settle();
    total++; if (o_owner !== 4'b0000) begin bad++; $display("FAIL midrst_owner got=%b exp=0000", o_owner); end
    total++; if (o_cmd !== 8'h00) begin bad++; $display("FAIL midrst_command got=%h exp=00", o_cmd); end
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready_partial got=%b exp=0", o_ready); end
    cmd_rdy = '1;
    settle();
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready_all got=%b exp=1", o_ready); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 149) == 0);
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_rdy   = ($urandom_range(0, 7) == 0) ? N'($urandom) : '1;
      case ($urandom_range(0, 3))
        0:       start = '0;
        1:       start = N'($urandom);
        default: start = N'(1 << $urandom_range(0, N-1));
      endcase
      last     = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      acg_rdy  = 8'($urandom);
      acg_last = 8'($urandom);
      randomize_fields();
      settle();
      total++; if (o_ready !== e_ready) begin bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, o_ready, e_ready); end
      total++; if (o_valid !== e_valid) begin bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, o_valid, e_valid); end
      total++; if (o_owner !== e_owner) begin bad++; $display("FAIL rnd_owner c=%0d got=%b exp=%b", c, o_owner, e_owner); end
      total++; if (o_cmd !== e_cmd) begin bad++; $display("FAIL rnd_command c=%0d got=%h exp=%h", c, o_cmd, e_cmd); end
      total++; if (o_opt !== e_opt) begin bad++; $display("FAIL rnd_option c=%0d got=%h exp=%h", c, o_opt, e_opt); end
      total++; if (o_way !== e_way) begin bad++; $display("FAIL rnd_way c=%0d got=%h exp=%h", c, o_way, e_way); end
      total++; if (o_nod !== e_nod) begin bad++; $display("FAIL rnd_numdata c=%0d got=%h exp=%h", c, o_nod, e_nod); end
      total++; if (o_cas !== e_cas) begin bad++; $display("FAIL rnd_caselect c=%0d got=%b exp=%b", c, o_cas, e_cas); end
      total++; if (o_cad !== e_cad) begin bad++; $display("FAIL rnd_cadata c=%0d got=%h exp=%h", c, o_cad, e_cad); end
      total++; if (o_rret !== e_rret) begin bad++; $display("FAIL rnd_ready_route c=%0d got=%h exp=%h", c, o_rret, e_rret); end
      total++; if (o_lret !== e_lret) begin bad++; $display("FAIL rnd_last_route c=%0d got=%h exp=%h", c, o_lret, e_lret); end
      total++; if (o_err !== m_err) begin bad++; $display("FAIL rnd_decode_err c=%0d got=%b exp=%b", c, o_err, m_err); end
      total++; if (o_to !== m_to) begin bad++; $display("FAIL rnd_timeout c=%0d got=%b exp=%b", c, o_to, m_to); end
      tick();
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    m_owner = -1; m_cycles = 0; m_err = 1'b0; m_to = 1'b0;
    idle_inputs();
    randomize_fields();
    test_reset();
    test_claim_release();
    test_decode_error();
    test_foreign_laststep();
    test_timeout();
    test_timeout_laststep();
    test_reset_mid_own();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_time_limit reached without finishing");
    $fatal(1);
  end

endmodule
